// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding instruction-memory
// request handshake and the IF/ID pipeline register. A stall freezes PC and
// IF/ID. A flush kills the fetched instruction and redirects the PC.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] instruction_d,
  output logic             valid_d
);

  // IDLE: first cycle after reset. FETCH: request outstanding at pc_f.
  // HOLD: response captured during a stall. DROP: waiting out a killed request.
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_f_reg, pc_f_next;
  logic [WIDTH-1:0] req_addr_reg, req_addr_next;
  logic [WIDTH-1:0] pc_d_reg, pc_d_next;
  logic [WIDTH-1:0] instr_d_reg, instr_d_next;
  logic             valid_d_reg, valid_d_next;
  logic [WIDTH-1:0] hold_buf_reg, hold_buf_next;

  logic [WIDTH-1:0] pc_f_inc;
  logic [WIDTH-1:0] target_pc;
  logic             unused_low_bits;

  // Sequential PC wraps modulo 2^WIDTH; redirect targets are forced word aligned.
  assign pc_f_inc        = pc_f_reg + WIDTH'(4);
  assign target_pc       = {redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  // A request is live in FETCH and DROP; address is held in a register so it
  // stays stable until the response is seen.
  assign imem_req      = (state_reg == FETCH) || (state_reg == DROP);
  assign imem_addr     = req_addr_reg;
  assign pc_d          = pc_d_reg;
  assign instruction_d = instr_d_reg;
  assign valid_d       = valid_d_reg;

  // Next-state and IF/ID update; every register holds unless a case says otherwise.
  always_comb begin
    state_next    = state_reg;
    pc_f_next     = pc_f_reg;
    req_addr_next = req_addr_reg;
    pc_d_next     = pc_d_reg;
    instr_d_next  = instr_d_reg;
    valid_d_next  = valid_d_reg;
    hold_buf_next = hold_buf_reg;
    case (state_reg)
      IDLE: begin
        state_next    = FETCH;
        req_addr_next = pc_f_reg;
      end
      FETCH: begin
        if (flush) begin
          instr_d_next = NOP;
          valid_d_next = 1'b0;
          pc_f_next    = target_pc;
          if (imem_rvalid) begin
            req_addr_next = target_pc;
          end else begin
            // The killed request must still complete before a new one issues.
            state_next = DROP;
          end
        end else if (imem_rvalid) begin
          if (stall) begin
            hold_buf_next = imem_rdata;
            state_next    = HOLD;
          end else begin
            pc_d_next     = pc_f_reg;
            instr_d_next  = imem_rdata;
            valid_d_next  = 1'b1;
            pc_f_next     = pc_f_inc;
            req_addr_next = pc_f_inc;
          end
        end else if (!stall) begin
          instr_d_next = NOP;
          valid_d_next = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          instr_d_next  = NOP;
          valid_d_next  = 1'b0;
          pc_f_next     = target_pc;
          req_addr_next = target_pc;
          state_next    = FETCH;
        end else if (!stall) begin
          pc_d_next     = pc_f_reg;
          instr_d_next  = hold_buf_reg;
          valid_d_next  = 1'b1;
          pc_f_next     = pc_f_inc;
          req_addr_next = pc_f_inc;
          state_next    = FETCH;
        end
      end
      DROP: begin
        if (flush) begin
          instr_d_next = NOP;
          valid_d_next = 1'b0;
          pc_f_next    = target_pc;
          if (imem_rvalid) begin
            req_addr_next = target_pc;
            state_next    = FETCH;
          end
        end else begin
          if (imem_rvalid) begin
            req_addr_next = pc_f_reg;
            state_next    = FETCH;
          end
          if (!stall) begin
            instr_d_next = NOP;
            valid_d_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_f_reg     <= RESET_PC;
      req_addr_reg <= RESET_PC;
      pc_d_reg     <= '0;
      instr_d_reg  <= NOP;
      valid_d_reg  <= 1'b0;
      hold_buf_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_f_reg     <= pc_f_next;
      req_addr_reg <= req_addr_next;
      pc_d_reg     <= pc_d_next;
      instr_d_reg  <= instr_d_next;
      valid_d_reg  <= valid_d_next;
      hold_buf_reg <= hold_buf_next;
    end
  end

endmodule
